// File: rtl/csync_separator.sv
// Composite-sync separator: a flywheel line counter locked to csync falling edges
// regenerates fixed-width hsync, and long low csync spans are decoded into vsync.
module csync_separator #(
  parameter int unsigned CLK_FREQ     = 32'd102000000,
  parameter int unsigned HSYNC_FREQ   = 32'd15666,
  parameter int unsigned PULSE_NS     = 32'd5000,
  parameter int unsigned VSYNC_NS     = 32'd20000,
  parameter int unsigned WINDOW_TICKS = 32'd64,
  parameter int unsigned LOCK_LINES   = 32'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic csync,
  output logic hsync,
  output logic vsync,
  output logic locked
);

  localparam int unsigned LINE_TICKS  = CLK_FREQ / HSYNC_FREQ;
  localparam int unsigned PULSE_TICKS = 32'((64'(CLK_FREQ) * 64'(PULSE_NS)) / 64'd1000000000);
  localparam int unsigned VSYNC_TICKS = 32'((64'(CLK_FREQ) * 64'(VSYNC_NS)) / 64'd1000000000);
  localparam int          W           = $clog2(LINE_TICKS) + 1;
  localparam int          GW          = $clog2(LOCK_LINES + 1);

  localparam logic [W-1:0]  LINE_LAST   = W'(LINE_TICKS - 1);
  localparam logic [W-1:0]  WIN_OPEN    = W'(LINE_TICKS - WINDOW_TICKS);
  localparam logic [W-1:0]  WIN_CLOSE   = W'(WINDOW_TICKS);
  localparam logic [W-1:0]  PULSE_END   = W'(PULSE_TICKS);
  localparam logic [W-1:0]  VS_POINT    = W'(VSYNC_TICKS);
  localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_LINES - 1);

  typedef enum logic [0:0] {S_SEARCH = 1'b0, S_LOCKED = 1'b1} lock_state_e;
  typedef enum logic [0:0] {V_IDLE = 1'b0, V_ACTIVE = 1'b1} vs_state_e;

  logic [1:0]    sync_r;
  logic          prev_r;
  logic          fall_r;
  logic [W-1:0]  dot_cnt_r, dot_nxt_s;
  logic [W-1:0]  low_run_r, low_nxt_s;
  logic          seen_r, seen_nxt_s;
  logic [GW-1:0] good_cnt_r, good_nxt_s;
  logic [1:0]    miss_cnt_r, miss_nxt_s;
  lock_state_e   lock_state_r, lock_nxt_s;
  vs_state_e     vs_state_r, vs_nxt_s;
  logic          hsync_r, vsync_r, locked_r;
  logic          in_window_s, accept_s, miss_s, stay_locked_s, classify_s, long_s;

  assign in_window_s   = (dot_cnt_r >= WIN_OPEN) || (dot_cnt_r < WIN_CLOSE);
  assign accept_s      = fall_r && ((lock_state_r == S_SEARCH) || in_window_s);
  assign miss_s        = (lock_state_r == S_LOCKED) && (dot_cnt_r == WIN_CLOSE) && !seen_r;
  assign stay_locked_s = (lock_state_r == S_LOCKED) && (lock_nxt_s == S_LOCKED);
  assign classify_s    = (dot_cnt_r == VS_POINT);
  assign long_s        = (low_run_r == VS_POINT);

  // Two-flop synchroniser followed by a registered falling-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b11;
      prev_r <= 1'b1;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], csync};
      prev_r <= sync_r[1];
      fall_r <= prev_r & ~sync_r[1];
    end
  end

  // Flywheel dot counter, low-span counter and window-seen flag next values
  always_comb begin
    dot_nxt_s  = dot_cnt_r + W'(1);
    low_nxt_s  = low_run_r;
    seen_nxt_s = seen_r;
    if (accept_s || (dot_cnt_r == LINE_LAST)) begin
      dot_nxt_s = '0;
    end else begin
      dot_nxt_s = dot_cnt_r + W'(1);
    end
    if (fall_r) begin
      low_nxt_s = '0;
    end else if (!sync_r[1] && (low_run_r < VS_POINT)) begin
      low_nxt_s = low_run_r + W'(1);
    end else begin
      low_nxt_s = low_run_r;
    end
    // The seen flag re-arms when the acceptance window opens each line
    if (accept_s) begin
      seen_nxt_s = 1'b1;
    end else if (dot_cnt_r == WIN_OPEN) begin
      seen_nxt_s = 1'b0;
    end else begin
      seen_nxt_s = seen_r;
    end
  end

  // Lock FSM: count in-window edges to lock, count missed lines to drop lock
  always_comb begin
    lock_nxt_s = lock_state_r;
    good_nxt_s = good_cnt_r;
    miss_nxt_s = miss_cnt_r;
    case (lock_state_r)
      S_SEARCH: begin
        miss_nxt_s = 2'd0;
        if (fall_r && in_window_s) begin
          if (good_cnt_r == GOOD_LAST) begin
            lock_nxt_s = S_LOCKED;
            good_nxt_s = '0;
          end else begin
            good_nxt_s = good_cnt_r + GW'(1);
          end
        end else if (fall_r) begin
          good_nxt_s = '0;
        end else begin
          good_nxt_s = good_cnt_r;
        end
      end
      S_LOCKED: begin
        good_nxt_s = '0;
        if (accept_s) begin
          miss_nxt_s = 2'd0;
        end else if (miss_s && (miss_cnt_r == 2'd1)) begin
          lock_nxt_s = S_SEARCH;
          miss_nxt_s = 2'd0;
        end else if (miss_s) begin
          miss_nxt_s = miss_cnt_r + 2'd1;
        end else begin
          miss_nxt_s = miss_cnt_r;
        end
      end
      default: begin
        lock_nxt_s = S_SEARCH;
        good_nxt_s = '0;
        miss_nxt_s = 2'd0;
      end
    endcase
  end

  // Vsync FSM: one decision per line, only while lock is held
  always_comb begin
    vs_nxt_s = vs_state_r;
    if (!stay_locked_s) begin
      vs_nxt_s = V_IDLE;
    end else if (classify_s) begin
      case (vs_state_r)
        V_IDLE:   vs_nxt_s = long_s ? V_ACTIVE : V_IDLE;
        V_ACTIVE: vs_nxt_s = long_s ? V_ACTIVE : V_IDLE;
        default:  vs_nxt_s = V_IDLE;
      endcase
    end else begin
      vs_nxt_s = vs_state_r;
    end
  end

  // State registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      dot_cnt_r    <= '0;
      low_run_r    <= '0;
      seen_r       <= 1'b0;
      good_cnt_r   <= '0;
      miss_cnt_r   <= 2'd0;
      lock_state_r <= S_SEARCH;
      vs_state_r   <= V_IDLE;
      hsync_r      <= 1'b1;
      vsync_r      <= 1'b1;
      locked_r     <= 1'b0;
    end else begin
      dot_cnt_r    <= dot_nxt_s;
      low_run_r    <= low_nxt_s;
      seen_r       <= seen_nxt_s;
      good_cnt_r   <= good_nxt_s;
      miss_cnt_r   <= miss_nxt_s;
      lock_state_r <= lock_nxt_s;
      vs_state_r   <= vs_nxt_s;
      hsync_r      <= ~(dot_cnt_r < PULSE_END);
      vsync_r      <= (vs_nxt_s != V_ACTIVE);
      locked_r     <= (lock_nxt_s == S_LOCKED);
    end
  end

  assign hsync  = hsync_r;
  assign vsync  = vsync_r;
  assign locked = locked_r;

endmodule

// File: tb/tb_csync_separator.sv
// Bench for csync_separator: randomized csync line streams compared every cycle
// against a sample-history reference model of hsync, vsync and lock.
module tb_csync_separator;

  localparam int LINE   = 651;
  localparam int PULSE  = 51;
  localparam int VSYNC  = 204;
  localparam int WIN    = 64;
  localparam int LOCKN  = 4;
  localparam int LONGLO = 600;
  localparam int MAXN   = 70000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic csync = 1'b1;
  logic hsync, vsync, locked;

  csync_separator #(
    .CLK_FREQ    (32'd10200000),
    .HSYNC_FREQ  (32'd15666),
    .PULSE_NS    (32'd5000),
    .VSYNC_NS    (32'd20000),
    .WINDOW_TICKS(32'd64),
    .LOCK_LINES  (32'd4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .csync (csync),
    .hsync (hsync),
    .vsync (vsync),
    .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int anchor = 0;
  int last_rst = 0;
  int good = 0;
  int miss = 0;
  bit m_locked = 1'b0;
  bit vact = 1'b0;
  bit exp_h = 1'b1, exp_v = 1'b1, exp_l = 1'b0;
  bit samp [MAXN];

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0b expected=%0b", tag, n, obs, exp);
    end
  endtask

  function automatic bit s_at(int i);
    return (i < 0) ? 1'b1 : samp[i];
  endfunction

  // Low span since the most recent fall, counted in synchronised samples.
  function automatic bit line_is_long(int e);
    int f = -1;
    int cnt = 0;
    for (int i = e - 4; i > last_rst; i--) begin
      if (!samp[i] && samp[i-1]) begin
        f = i;
        break;
      end
    end
    if (f < 0) return 1'b0;
    for (int i = f + 2; i <= e - 3; i++) begin
      if (samp[i]) break;
      cnt++;
    end
    return cnt >= VSYNC;
  endfunction

  task automatic model_edge(input bit c, input bit r);
    int prevdot;
    bit fall, inwin, acc, was_locked;
    samp[n] = c;
    if (r) begin
      samp[n] = 1'b1;
      if (n >= 1) samp[n-1] = 1'b1;
      if (n >= 2) samp[n-2] = 1'b1;
      anchor = n; last_rst = n;
      m_locked = 1'b0; good = 0; miss = 0; vact = 1'b0;
      exp_h = 1'b1; exp_v = 1'b1; exp_l = 1'b0;
      return;
    end
    prevdot = (n - 1 - anchor) % LINE;
    fall    = !s_at(n - 3) && s_at(n - 4);
    inwin   = (prevdot >= LINE - WIN) || (prevdot < WIN);
    exp_h   = !(prevdot < PULSE);
    was_locked = m_locked;
    acc = 1'b0;
    if (was_locked) begin
      acc = fall && inwin;
      if (acc) miss = 0;
      else if (prevdot == WIN && (n - 1 - anchor) > WIN) begin
        miss++;
        if (miss == 2) begin
          m_locked = 1'b0; good = 0; miss = 0;
        end
      end
    end else if (fall) begin
      acc = 1'b1;
      if (inwin) begin
        good++;
        if (good == LOCKN) begin
          m_locked = 1'b1; good = 0;
        end
      end else good = 0;
    end
    if (!m_locked) vact = 1'b0;
    else if (was_locked && prevdot == VSYNC) vact = line_is_long(n);
    if (acc) anchor = n;
    exp_v = !vact;
    exp_l = m_locked;
  endtask

  task automatic step(input bit c, input bit r);
    csync = c;
    rst = r;
    @(posedge clk);
    model_edge(c, r);
    n++;
    @(negedge clk);
    check("hsync", hsync, exp_h);
    check("vsync", vsync, exp_v);
    check("locked", locked, exp_l);
  endtask

  task automatic emit_line(input int period, input int lo, input int glitch_at);
    for (int i = 0; i < period; i++) begin
      bit c;
      c = (i < lo) ? 1'b0 : 1'b1;
      if (glitch_at > 0 && i >= glitch_at && i < glitch_at + 10) c = 1'b0;
      step(c, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) step(1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) emit_line(LINE, PULSE, 0);
    for (int i = 0; i < 3; i++) emit_line(LINE, LONGLO, 0);
    for (int i = 0; i < 4; i++) emit_line(LINE, PULSE, 0);
    emit_line(LINE, 0, 0);
    for (int i = 0; i < 2; i++) emit_line(LINE, PULSE, 0);
    for (int i = 0; i < 2; i++) emit_line(LINE, 0, 0);
    for (int i = 0; i < 6; i++) emit_line(LINE, PULSE, 0);
    emit_line(LINE, PULSE, 300);
    emit_line(LINE, PULSE, 0);
    for (int i = 0; i < 2; i++) emit_line(LINE, LONGLO, 0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) emit_line(LINE, PULSE, 0);
    for (int k = 0; k < 24; k++) begin
      int r, period, lo, g;
      r = int'($urandom_range(0, 15));
      period = LINE + int'($urandom_range(0, 6)) - 3;
      if (r == 0) period = LINE + int'($urandom_range(0, 300)) - 150;
      lo = (r < 3) ? LONGLO : (r == 3) ? 0 : (r == 4) ? int'($urandom_range(5, 300)) : PULSE;
      if (lo > period - 20) lo = period - 20;
      g = 0;
      if (r == 5) g = int'($urandom_range(lo + 20, period - 30));
      emit_line(period, lo, g);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
